nl2_new_dbank_rd_data: RTL and testbench

- Downstream stage of the dbank read controller, in the dbank_ctrl_clk domain.
- Captures the read data of the SRAM selected by the controller's 1-hot data select during its pop cycle, together with that beat's sideband (id, last, excl_ok, tag_err, ecc_en).
- Registers the beat, buffers it in a response queue and presents it on a valid/ready response channel toward the CLN.
- Returns rd_stall to the controller through a credit counter, so an issued SRAM read always has buffer space when its data returns.

---
 rtl/nl2_dbank_rd_pkg.sv | 31 +++
 rtl/nl2_cln_fifo.sv | 50 +++++
 rtl/nl2_new_dbank_rd_data.sv | 152 +++++++++++++++
 tb/tb_nl2_new_dbank_rd_data.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nl2_dbank_rd_pkg.sv
// rtl/nl2_dbank_rd_pkg.sv - shared beat type, sizing constants and select mux for the dbank read data stage
package nl2_dbank_rd_pkg;

   localparam int RD_DATA_W   = 64;
   localparam int RD_ID_W     = 1;
   localparam int RD_MAX_SRAM = 4;
   localparam int RD_DEPTH    = 4;
   localparam int RD_CREDIT_W = $clog2(RD_DEPTH + 1);

   typedef struct packed {
      logic [RD_DATA_W-1:0] data;
      logic [RD_ID_W-1:0]   id;
      logic                 last;
      logic                 excl_ok;
      logic                 tag_err;
      logic                 err;
   } rd_beat_s;

   // AND-OR mux: a bad select ORs the chosen words instead of picking a winner
   function automatic logic [RD_DATA_W-1:0] onehot_mux(
      input logic [RD_MAX_SRAM-1:0]           sel,
      input logic [RD_MAX_SRAM*RD_DATA_W-1:0] data
   );
      logic [RD_DATA_W-1:0] res;
      res = '0;
      for (int i = 0; i < RD_MAX_SRAM; i++)
         res = res | (data[i*RD_DATA_W +: RD_DATA_W] & {RD_DATA_W{sel[i]}});
      return res;
   endfunction

endpackage

// File: rtl/nl2_cln_fifo.sv
// rtl/nl2_cln_fifo.sv - synchronous FIFO, head shown combinationally, push and pop allowed together when full
module nl2_cln_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_a,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic             full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst_a) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   assign head_data = mem[rd_ptr];

endmodule

// File: rtl/nl2_new_dbank_rd_data.sv
// rtl/nl2_new_dbank_rd_data.sv - dbank read data capture, response queue and credit-based rd_stall
// Byte parity check on captured beats is built only when NL2_DBANK_RD_PARITY_EN is defined.
module nl2_new_dbank_rd_data
   import nl2_dbank_rd_pkg::*;
#(
   parameter int N_SRAM         = 4,
   parameter int BNK_DATA_WIDTH = RD_DATA_W,
   parameter int CMD_ID_SIZE    = RD_ID_W,
   parameter int DEPTH          = RD_DEPTH
) (
   input  logic                               dbank_ctrl_clk,
   input  logic                               rst_a,
   input  logic                               rd_issue,
   input  logic                               rd_valid,
   input  logic [N_SRAM-1:0]                  rd_sel,
   input  logic [N_SRAM*BNK_DATA_WIDTH-1:0]   rd_data,
   input  logic [N_SRAM*BNK_DATA_WIDTH/8-1:0] rd_par,
   input  logic                               rd_ecc_en,
   input  logic                               rd_last,
   input  logic                               rd_excl_ok,
   input  logic                               rd_tag_err,
   input  logic [CMD_ID_SIZE-1:0]             rd_id,
   output logic                               rd_stall,
   output logic                               rsp_valid,
   input  logic                               rsp_ready,
   output logic [BNK_DATA_WIDTH-1:0]          rsp_data,
   output logic [CMD_ID_SIZE-1:0]             rsp_id,
   output logic                               rsp_last,
   output logic                               rsp_excl_ok,
   output logic                               rsp_tag_err,
   output logic                               rsp_err,
`ifdef NL2_DBANK_RD_PARITY_EN
   output logic                               rd_par_err_sts,
`endif
   output logic                               rd_data_idle
);

   localparam int CNT_W = (DEPTH == RD_DEPTH) ? RD_CREDIT_W : $clog2(DEPTH + 1);

   logic [CNT_W-1:0]                 credit;
   logic                             rsp_hs, take_credit;
   logic [RD_MAX_SRAM-1:0]           sel_ext;
   logic [RD_MAX_SRAM*RD_DATA_W-1:0] data_ext;
   logic [RD_DATA_W-1:0]             cap_data;
   logic                             par_flag;
   rd_beat_s                         cap_beat, s1_beat, rsp_beat;
   logic                             s1_valid;
   logic [$bits(rd_beat_s)-1:0]      q_head;
   logic                             q_empty, q_full;

   assign rsp_hs      = rsp_valid && rsp_ready;
   assign take_credit = rd_issue && (credit != '0);
   assign rd_stall    = (credit == '0);

   // One credit per queue slot: a read is only issued once its beat has a guaranteed home
   always_ff @(posedge dbank_ctrl_clk) begin
      if (rst_a)
         credit <= CNT_W'(DEPTH);
      else if (take_credit && !rsp_hs)
         credit <= credit - 1'b1;
      else if (rsp_hs && !take_credit)
         credit <= credit + 1'b1;
   end

   always_comb begin
      sel_ext  = '0;
      data_ext = '0;
      sel_ext[N_SRAM-1:0]                 = rd_sel;
      data_ext[N_SRAM*BNK_DATA_WIDTH-1:0] = rd_data;
   end

   assign cap_data = onehot_mux(sel_ext, data_ext);

`ifdef NL2_DBANK_RD_PARITY_EN
   localparam int PB = BNK_DATA_WIDTH / 8;
   logic [PB-1:0] sel_par;

   always_comb begin
      sel_par  = '0;
      par_flag = 1'b0;
      for (int i = 0; i < N_SRAM; i++)
         if (rd_sel[i]) sel_par = sel_par | rd_par[i*PB +: PB];
      for (int b = 0; b < PB; b++)
         if ((^cap_data[b*8 +: 8]) != sel_par[b]) par_flag = rd_ecc_en;
   end

   always_ff @(posedge dbank_ctrl_clk) begin
      if (rst_a)
         rd_par_err_sts <= 1'b0;
      else if (s1_valid && s1_beat.err)
         rd_par_err_sts <= 1'b1;
   end
`else
   logic unused_par;
   assign unused_par = ^{rd_par, rd_ecc_en};
   assign par_flag   = 1'b0;
`endif

   always_comb begin
      cap_beat         = '0;
      cap_beat.data    = cap_data;
      cap_beat.id      = rd_id;
      cap_beat.last    = rd_last;
      cap_beat.excl_ok = rd_excl_ok;
      cap_beat.tag_err = rd_tag_err;
      cap_beat.err     = par_flag;
   end

   always_ff @(posedge dbank_ctrl_clk) begin
      if (rst_a) begin
         s1_valid <= 1'b0;
         s1_beat  <= '0;
      end else begin
         s1_valid <= rd_valid;
         if (rd_valid)
            s1_beat <= cap_beat;
      end
   end

   nl2_cln_fifo #(
      .WIDTH ($bits(rd_beat_s)),
      .DEPTH (DEPTH)
   ) u_rsp_q (
      .clk       (dbank_ctrl_clk),
      .rst_a     (rst_a),
      .push      (s1_valid),
      .push_data (s1_beat),
      .pop       (rsp_hs),
      .head_data (q_head),
      .empty     (q_empty),
      .full      (q_full)
   );

   // Queue storage is not reset, so an empty head is forced to zero
   assign rsp_beat     = q_empty ? '0 : rd_beat_s'(q_head);
   assign rsp_valid    = !q_empty;
   assign rsp_data     = rsp_beat.data;
   assign rsp_id       = rsp_beat.id;
   assign rsp_last     = rsp_beat.last;
   assign rsp_excl_ok  = rsp_beat.excl_ok;
   assign rsp_tag_err  = rsp_beat.tag_err;
   assign rsp_err      = rsp_beat.err;
   assign rd_data_idle = !s1_valid && q_empty && (credit == CNT_W'(DEPTH));

   a_issue_has_credit: assert property (@(posedge dbank_ctrl_clk) disable iff (rst_a)
      rd_issue |-> (credit != '0));
   a_sel_onehot: assert property (@(posedge dbank_ctrl_clk) disable iff (rst_a)
      rd_valid |-> $onehot(rd_sel));
   a_no_overflow: assert property (@(posedge dbank_ctrl_clk) disable iff (rst_a)
      s1_valid |-> (!q_full || rsp_hs));

endmodule

// File: tb/tb_nl2_new_dbank_rd_data.sv
// tb/tb_nl2_new_dbank_rd_data.sv - randomized and directed bench for nl2_new_dbank_rd_data
`timescale 1ns/1ps
module tb_nl2_new_dbank_rd_data;

   localparam int N  = 4;
   localparam int W  = 64;
   localparam int PB = W / 8;
   localparam int D  = 4;

   logic           dbank_ctrl_clk = 1'b0;
   logic           rst_a, rd_issue, rd_valid, rd_ecc_en, rd_last, rd_excl_ok, rd_tag_err;
   logic [N-1:0]   rd_sel;
   logic [N*W-1:0] rd_data;
   logic [N*PB-1:0] rd_par;
   logic [0:0]     rd_id, rsp_id;
   logic           rd_stall, rsp_valid, rsp_ready, rsp_last, rsp_excl_ok, rsp_tag_err, rsp_err;
   logic [W-1:0]   rsp_data;
   logic           rd_data_idle;
`ifdef NL2_DBANK_RD_PARITY_EN
   logic           rd_par_err_sts;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [W-1:0]  data;
      logic          id, last, excl, tag, ecc;
      logic [PB-1:0] flip;
      int            bank;
      int            due;
   } beat_t;

   nl2_new_dbank_rd_data dut (
      .dbank_ctrl_clk (dbank_ctrl_clk),
      .rst_a          (rst_a),
      .rd_issue       (rd_issue),
      .rd_valid       (rd_valid),
      .rd_sel         (rd_sel),
      .rd_data        (rd_data),
      .rd_par         (rd_par),
      .rd_ecc_en      (rd_ecc_en),
      .rd_last        (rd_last),
      .rd_excl_ok     (rd_excl_ok),
      .rd_tag_err     (rd_tag_err),
      .rd_id          (rd_id),
      .rd_stall       (rd_stall),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_data       (rsp_data),
      .rsp_id         (rsp_id),
      .rsp_last       (rsp_last),
      .rsp_excl_ok    (rsp_excl_ok),
      .rsp_tag_err    (rsp_tag_err),
      .rsp_err        (rsp_err),
`ifdef NL2_DBANK_RD_PARITY_EN
      .rd_par_err_sts (rd_par_err_sts),
`endif
      .rd_data_idle   (rd_data_idle)
   );

   always #5 dbank_ctrl_clk = ~dbank_ctrl_clk;

   task automatic tick();
      @(posedge dbank_ctrl_clk);
      #1;
      cyc++;
   endtask

   function automatic logic [PB-1:0] par_of(input logic [W-1:0] w);
      logic [PB-1:0] p;
      for (int b = 0; b < PB; b++) p[b] = ^w[b*8 +: 8];
      return p;
   endfunction

   function automatic logic exp_err(input beat_t b);
`ifdef NL2_DBANK_RD_PARITY_EN
      return b.ecc && (b.flip != '0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic beat_t rand_beat();
      beat_t b;
      b.data = {$urandom, $urandom};
      b.id   = 1'($urandom_range(0, 1));
      b.last = 1'($urandom_range(0, 1));
      b.excl = 1'($urandom_range(0, 1));
      b.tag  = 1'($urandom_range(0, 1));
      b.ecc  = 1'($urandom_range(0, 1));
      b.flip = ($urandom_range(0, 3) == 0) ? (PB'(1) << $urandom_range(0, PB - 1)) : '0;
      b.bank = $urandom_range(0, N - 1);
      b.due  = 0;
      return b;
   endfunction

   task automatic drive_idle();
      rd_issue = 1'b0; rd_valid = 1'b0; rd_sel = '0; rd_data = '0; rd_par = '0;
      rd_ecc_en = 1'b0; rd_last = 1'b0; rd_excl_ok = 1'b0; rd_tag_err = 1'b0; rd_id = '0;
   endtask

   task automatic drive_pop(input beat_t b);
      logic [W-1:0] w;
      rd_valid = 1'b1;
      rd_sel   = '0;
      rd_sel[b.bank] = 1'b1;
      for (int i = 0; i < N; i++) begin
         w = (i == b.bank) ? b.data : {$urandom, $urandom};
         rd_data[i*W +: W] = w;
         rd_par[i*PB +: PB] = par_of(w) ^ ((i == b.bank) ? b.flip : '0);
      end
      rd_id = b.id; rd_last = b.last; rd_excl_ok = b.excl; rd_tag_err = b.tag; rd_ecc_en = b.ecc;
   endtask

   // Controller-like issue: read k issued in cycle k, its data popped in cycle k+1
   task automatic issue_beats(input beat_t bs[$]);
      for (int k = 0; k <= bs.size(); k++) begin
         drive_idle();
         if (k > 0) drive_pop(bs[k-1]);
         rd_issue = (k < bs.size());
         tick();
      end
      drive_idle();
   endtask

   task automatic do_reset();
      rst_a = 1'b1; rsp_ready = 1'b0;
      drive_idle();
      tick();
      tick();
      rst_a = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", rsp_valid); end
      total++; if ({rsp_data, rsp_id, rsp_last, rsp_excl_ok, rsp_tag_err, rsp_err} !== '0) begin
         bad++; $display("FAIL reset_payload got=%h exp=0", {rsp_data, rsp_id, rsp_last, rsp_excl_ok, rsp_tag_err, rsp_err}); end
      total++; if (rd_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", rd_stall); end
      total++; if (rd_data_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%0b exp=1", rd_data_idle); end
`ifdef NL2_DBANK_RD_PARITY_EN
      total++; if (rd_par_err_sts !== 1'b0) begin bad++; $display("FAIL reset_sts got=%0b exp=0", rd_par_err_sts); end
`endif
   endtask

   task automatic test_stall();
      do_reset();
      for (int k = 1; k <= D; k++) begin
         rd_issue = 1'b1;
         tick();
         total++; if (rd_stall !== (k == D)) begin bad++; $display("FAIL stall_after_%0d got=%0b exp=%0b", k, rd_stall, k == D); end
      end
      rd_issue = 1'b0;
      total++; if (rd_data_idle !== 1'b0) begin bad++; $display("FAIL stall_idle got=%0b exp=0", rd_data_idle); end
   endtask

   task automatic test_single();
      beat_t b;
      do_reset();
      b = rand_beat();
      b.data = 64'hA5A5_0000_1234_5678; b.bank = 2; b.id = 1'b1; b.last = 1'b1;
      b.excl = 1'b0; b.tag = 1'b0; b.ecc = 1'b0; b.flip = '0;
      rd_issue = 1'b1;
      tick();
      drive_idle();
      drive_pop(b);
      tick();
      drive_idle();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%0b exp=0", rsp_valid); end
      tick();
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", rsp_valid); end
      total++; if ({rsp_data, rsp_id, rsp_last, rsp_excl_ok, rsp_tag_err, rsp_err} !== {64'hA5A5_0000_1234_5678, 1'b1, 1'b1, 3'b000}) begin
         bad++; $display("FAIL single_payload got=%h id=%0b last=%0b exp=a5a5000012345678 id=1 last=1", rsp_data, rsp_id, rsp_last); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      total++; if ({rsp_valid, rd_data_idle} !== 2'b01) begin bad++; $display("FAIL single_done got=%b exp=01", {rsp_valid, rd_data_idle}); end
   endtask

   task automatic test_burst();
      beat_t bs[$];
      do_reset();
      for (int k = 0; k < D; k++) bs.push_back(rand_beat());
      issue_beats(bs);
      tick();
      for (int h = 0; h < 3; h++) begin
         total++; if ({rsp_valid, rd_stall} !== 2'b11) begin bad++; $display("FAIL burst_full_%0d got=%b exp=11", h, {rsp_valid, rd_stall}); end
         total++; if ({rsp_data, rsp_id} !== {bs[0].data, bs[0].id}) begin
            bad++; $display("FAIL burst_hold_%0d got=%h exp=%h", h, rsp_data, bs[0].data); end
         tick();
      end
      rsp_ready = 1'b1;
      for (int k = 0; k < D; k++) begin
         total++; if ({rsp_valid, rsp_data, rsp_id, rsp_last, rsp_excl_ok, rsp_tag_err, rsp_err} !==
                      {1'b1, bs[k].data, bs[k].id, bs[k].last, bs[k].excl, bs[k].tag, exp_err(bs[k])}) begin
            bad++; $display("FAIL burst_beat_%0d got=%h exp=%h", k, rsp_data, bs[k].data); end
         tick();
      end
      rsp_ready = 1'b0;
      total++; if ({rsp_valid, rd_stall, rd_data_idle} !== 3'b001) begin
         bad++; $display("FAIL burst_end got=%b exp=001", {rsp_valid, rd_stall, rd_data_idle}); end
   endtask

   task automatic test_simul();
      beat_t bs[$];
      beat_t ex[$];
      beat_t bx, by;
      int hs, idx;
      do_reset();
      for (int k = 0; k < D - 1; k++) bs.push_back(rand_beat());
      issue_beats(bs);
      tick();
      bx = rand_beat(); by = rand_beat();
      ex.push_back(bs[1]); ex.push_back(bs[2]); ex.push_back(bx); ex.push_back(by);
      total++; if (rd_stall !== 1'b0) begin bad++; $display("FAIL simul_pre got=%0b exp=0", rd_stall); end
      rd_issue = 1'b1; rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      total++; if (rd_stall !== 1'b0) begin bad++; $display("FAIL simul_stall got=%0b exp=0", rd_stall); end
      drive_idle();
      drive_pop(bx);
      rd_issue = 1'b1;
      tick();
      total++; if (rd_stall !== 1'b1) begin bad++; $display("FAIL simul_last_credit got=%0b exp=1", rd_stall); end
      drive_idle();
      drive_pop(by);
      tick();
      drive_idle();
      rsp_ready = 1'b1;
      hs = 0; idx = 0;
      for (int c = 0; c < 10; c++) begin
         if (rsp_valid === 1'b1) begin
            total++; if (idx >= ex.size() || rsp_data !== ex[idx].data) begin
               bad++; $display("FAIL simul_order_%0d got=%h exp=%h", idx, rsp_data, (idx < ex.size()) ? ex[idx].data : '0); end
            idx++; hs++;
         end
         tick();
      end
      rsp_ready = 1'b0;
      total++; if (hs !== 4) begin bad++; $display("FAIL simul_count got=%0d exp=4", hs); end
      total++; if ({rd_stall, rd_data_idle} !== 2'b01) begin bad++; $display("FAIL simul_idle got=%b exp=01", {rd_stall, rd_data_idle}); end
   endtask

   task automatic test_parity();
`ifdef NL2_DBANK_RD_PARITY_EN
      beat_t bs[$];
      beat_t b;
      do_reset();
      b = rand_beat(); b.ecc = 1'b1; b.flip = PB'(8); bs.push_back(b);
      b = rand_beat(); b.ecc = 1'b1; b.flip = '0;     bs.push_back(b);
      b = rand_beat(); b.ecc = 1'b0; b.flip = PB'(8); bs.push_back(b);
      issue_beats(bs);
      tick();
      rsp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         total++; if ({rsp_valid, rsp_err} !== {1'b1, (k == 0)}) begin
            bad++; $display("FAIL parity_err_%0d got=%b exp=%b", k, {rsp_valid, rsp_err}, {1'b1, (k == 0)}); end
         tick();
      end
      rsp_ready = 1'b0;
      total++; if (rd_par_err_sts !== 1'b1) begin bad++; $display("FAIL parity_sts got=%0b exp=1", rd_par_err_sts); end
`endif
   endtask

   task automatic test_reset_mid();
      beat_t bs[$];
      do_reset();
      for (int k = 0; k < 3; k++) bs.push_back(rand_beat());
      issue_beats(bs);
      tick();
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%0b exp=1", rsp_valid); end
      rst_a = 1'b1;
      tick();
      total++; if ({rsp_valid, rd_stall, rd_data_idle} !== 3'b001) begin
         bad++; $display("FAIL rstmid_state got=%b exp=001", {rsp_valid, rd_stall, rd_data_idle}); end
      total++; if (rsp_data !== '0) begin bad++; $display("FAIL rstmid_data got=%h exp=0", rsp_data); end
      rst_a = 1'b0;
      tick();
   endtask

   task automatic test_random(input int n);
      beat_t mq[$];
      beat_t pend;
      logic  pend_v, ev, iss, hs;
      int    cred;
      do_reset();
      cred = D; pend_v = 1'b0;
      for (int c = 0; c < n + 40; c++) begin
         ev = (mq.size() > 0) && (mq[0].due <= cyc);
         total++; if (rd_stall !== (cred == 0)) begin bad++; $display("FAIL rand_stall c=%0d got=%0b exp=%0b", c, rd_stall, cred == 0); end
         total++; if (rsp_valid !== ev) begin bad++; $display("FAIL rand_valid c=%0d got=%0b exp=%0b", c, rsp_valid, ev); end
         if (ev) begin
            total++; if ({rsp_data, rsp_id, rsp_last, rsp_excl_ok, rsp_tag_err, rsp_err} !==
                         {mq[0].data, mq[0].id, mq[0].last, mq[0].excl, mq[0].tag, exp_err(mq[0])}) begin
               bad++; $display("FAIL rand_beat c=%0d got=%h exp=%h", c,
                  {rsp_data, rsp_id, rsp_last, rsp_excl_ok, rsp_tag_err, rsp_err},
                  {mq[0].data, mq[0].id, mq[0].last, mq[0].excl, mq[0].tag, exp_err(mq[0])}); end
         end
         drive_idle();
         rsp_ready = (c >= n) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (pend_v) begin
            drive_pop(pend);
            pend.due = cyc + 2;
            mq.push_back(pend);
         end
         iss = (c < n) && (cred > 0) && ($urandom_range(0, 1) == 1);
         rd_issue = iss;
         pend_v = iss;
         if (iss) pend = rand_beat();
         hs = ev && rsp_ready;
         if (hs) void'(mq.pop_front());
         cred = cred - int'(iss) + int'(hs);
         tick();
      end
      rsp_ready = 1'b0;
      total++; if (mq.size() != 0) begin bad++; $display("FAIL rand_drain got=%0d exp=0", mq.size()); end
      total++; if (rd_data_idle !== 1'b1) begin bad++; $display("FAIL rand_idle got=%0b exp=1", rd_data_idle); end
   endtask

   initial begin
      rst_a = 1'b1; rsp_ready = 1'b0;
      drive_idle();
      test_reset();
      test_stall();
      test_single();
      test_burst();
      test_simul();
      test_parity();
      test_reset_mid();
      test_random(3000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
